// File: rtl/wb_to_fta_bridge_v2_if.sv
`default_nettype none
// fta_bus_pkg / fta_bus_interface -- FTA bus command/status codes and the
// request/response bundle shared by FTA masters and slaves.

package fta_bus_pkg;
   typedef logic [4:0] fta_cmd_t;
   localparam fta_cmd_t CMD_LOAD  = 5'd1;
   localparam fta_cmd_t CMD_STORE = 5'd2;

   typedef logic [2:0] fta_err_t;
   localparam fta_err_t OKAY = 3'd0;
   localparam fta_err_t ERR  = 3'd1;
endpackage

interface fta_bus_interface #(
   parameter int WID = 256
);
   typedef struct packed {
      logic                  cyc;
      logic                  we;
      fta_bus_pkg::fta_cmd_t cmd;
      logic [WID/8-1:0]      sel;
      logic [31:0]           adr;
      logic [WID-1:0]        data1;
      logic [7:0]            tid;
   } req_t;

   typedef struct packed {
      logic           ack;
      logic           rty;
      logic           err;
      logic           stall;
      logic [7:0]     tid;
      logic [WID-1:0] dat;
   } resp_t;

   req_t  req;
   resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);
endinterface

`default_nettype wire

// File: rtl/wb_to_fta_bridge_v2.sv
`default_nettype none
// wb_to_fta_bridge_v2 -- one classic Wishbone cycle in, one tagged FTA request out,
// with retry back-off, response timeout and optional posted writes. Rev 1.0.

module wb_to_fta_bridge_v2
   import fta_bus_pkg::*;
#(
   parameter int WID       = 256,
   parameter int RETRY_MAX = 10,
   parameter int BACKOFF   = 4,
   parameter int TIMEOUT   = 1023,
   parameter bit POSTED_WR = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cs_i,
   input  logic             cyc_i,
   input  logic             stb_i,
   output logic             ack_o,
   output logic [2:0]       err_o,
   input  logic             we_i,
   input  logic [WID/8-1:0] sel_i,
   input  logic [31:0]      adr_i,
   input  logic [WID-1:0]   dat_i,
   output logic [WID-1:0]   dat_o,
   fta_bus_interface.master fta_o
);

   localparam logic [7:0]  BO_LAST  = 8'(BACKOFF - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [5:0]  RTY_LIM  = 6'(RETRY_MAX);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_BACKOFF = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             we_q;
   logic [WID/8-1:0] sel_q;
   logic [31:0]      adr_q;
   logic [WID-1:0]   dat_q;
   logic [7:0]       tid;
   logic [5:0]       retry_cnt;
   logic [15:0]      tmo_cnt;
   logic [7:0]       bo_cnt;
   logic             accept;
   logic             hit;
   logic             take_ack;
   logic             fail;
   logic             retry;

   assign accept = (state == S_IDLE) && cyc_i && stb_i && cs_i;
   assign hit    = (fta_o.resp.tid == tid);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fta_o.req = '0;
      take_ack  = 1'b0;
      fail      = 1'b0;
      retry     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (!cyc_i) begin
               state_nxt = S_IDLE;
            end else if (!fta_o.resp.stall) begin
               fta_o.req.cyc   = 1'b1;
               fta_o.req.we    = we_q;
               fta_o.req.cmd   = we_q ? CMD_STORE : CMD_LOAD;
               fta_o.req.sel   = sel_q;
               fta_o.req.adr   = adr_q;
               fta_o.req.data1 = dat_q;
               fta_o.req.tid   = tid;
               state_nxt       = (we_q && POSTED_WR) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            // Response priority: ack, err, rty, then the timeout.
            if (!cyc_i) begin
               state_nxt = S_IDLE;
            end else if (hit && fta_o.resp.ack) begin
               take_ack  = 1'b1;
               state_nxt = S_DONE;
            end else if (hit && fta_o.resp.err) begin
               fail      = 1'b1;
               state_nxt = S_DONE;
            end else if (hit && fta_o.resp.rty) begin
               if (retry_cnt < RTY_LIM) begin
                  retry     = 1'b1;
                  state_nxt = (BACKOFF == 0) ? S_ISSUE : S_BACKOFF;
               end else begin
                  fail      = 1'b1;
                  state_nxt = S_DONE;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               fail      = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_BACKOFF: begin
            if (!cyc_i)                 state_nxt = S_IDLE;
            else if (bo_cnt == BO_LAST) state_nxt = S_ISSUE;
         end
         S_DONE: begin
            if (!cyc_i) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         tid       <= '0;
         retry_cnt <= '0;
         tmo_cnt   <= '0;
         bo_cnt    <= '0;
         ack_o     <= 1'b0;
         err_o     <= OKAY;
         dat_o     <= '0;
      end else begin
         if (accept) begin
            we_q      <= we_i;
            sel_q     <= sel_i;
            adr_q     <= adr_i;
            dat_q     <= dat_i;
            tid       <= tid + 8'd1;
            retry_cnt <= '0;
            err_o     <= OKAY;
         end
         if (retry) retry_cnt <= retry_cnt + 6'd1;
         if (fail)  err_o     <= ERR;
         // WAIT is always entered from ISSUE, so both counters restart at zero.
         tmo_cnt <= (state == S_WAIT)    ? tmo_cnt + 16'd1 : '0;
         bo_cnt  <= (state == S_BACKOFF) ? bo_cnt + 8'd1   : '0;
         ack_o   <= (state_nxt == S_DONE);
         if (take_ack)                dat_o <= fta_o.resp.dat;
         else if (state_nxt != S_DONE) dat_o <= '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_to_fta_bridge_v2.sv
`default_nettype none
// tb_wb_to_fta_bridge_v2 -- directed bench for the Wishbone to FTA bridge.

module tb_wb_to_fta_bridge_v2;
   import fta_bus_pkg::*;

   localparam int WID       = 64;
   localparam int RETRY_MAX = 10;
   localparam int BACKOFF   = 4;
   localparam int TIMEOUT   = 20;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             cs_i  = 1'b0;
   logic             cyc_i = 1'b0;
   logic             stb_i = 1'b0;
   logic             we_i  = 1'b0;
   logic [WID/8-1:0] sel_i = '0;
   logic [31:0]      adr_i = '0;
   logic [WID-1:0]   dat_i = '0;
   logic             ack_o;
   logic [2:0]       err_o;
   logic [WID-1:0]   dat_o;

   fta_bus_interface #(.WID(WID)) fta();

   wb_to_fta_bridge_v2 #(
      .WID      (WID),
      .RETRY_MAX(RETRY_MAX),
      .BACKOFF  (BACKOFF),
      .TIMEOUT  (TIMEOUT),
      .POSTED_WR(1'b1)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .cs_i (cs_i),
      .cyc_i(cyc_i),
      .stb_i(stb_i),
      .ack_o(ack_o),
      .err_o(err_o),
      .we_i (we_i),
      .sel_i(sel_i),
      .adr_i(adr_i),
      .dat_i(dat_i),
      .dat_o(dat_o),
      .fta_o(fta.master)
   );

   always #5 clk_i = ~clk_i;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_tid  = 8'd0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_bus();
      cs_i  = 1'b0;
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
   endtask

   // Presents a request and clocks it in; returns with the bridge in ISSUE.
   task automatic start_req(input logic we, input logic [31:0] adr, input logic [WID-1:0] dat);
      cs_i    = 1'b1;
      cyc_i   = 1'b1;
      stb_i   = 1'b1;
      we_i    = we;
      sel_i   = '1;
      adr_i   = adr;
      dat_i   = dat;
      exp_tid = exp_tid + 8'd1;
      tick();
   endtask

   task automatic end_cycle();
      idle_bus();
      tick();
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (fta.req.cyc !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      if (fta.req.cyc !== 1'b1) n = -1;
   endtask

   task automatic test_reset();
      fta.resp = '0;
      idle_bus();
      rst_i = 1'b0;
      exp_tid = 8'd0;
      repeat (3) tick();
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b want 0", ack_o); end
      n_checks++; if (err_o !== OKAY) begin n_fail++; $display("FAIL reset_err: got %0d want %0d", err_o, OKAY); end
      n_checks++; if (dat_o !== '0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat_o); end
      n_checks++; if (fta.req !== '0) begin n_fail++; $display("FAIL reset_req: got %h want 0", fta.req); end
      #2 rst_i = 1'b1;
      tick();
   endtask

   task automatic test_read();
      start_req(1'b0, 32'h1000, '0);
      n_checks++; if (fta.req.cyc !== 1'b1) begin n_fail++; $display("FAIL read_req_cyc: got %0b want 1", fta.req.cyc); end
      n_checks++; if (fta.req.cmd !== CMD_LOAD) begin n_fail++; $display("FAIL read_cmd: got %0d want %0d", fta.req.cmd, CMD_LOAD); end
      n_checks++; if (fta.req.tid !== 8'd1) begin n_fail++; $display("FAIL read_tid: got %0d want 1", fta.req.tid); end
      n_checks++; if (fta.req.adr !== 32'h1000 || fta.req.we !== 1'b0) begin n_fail++; $display("FAIL read_adr_we: got %h/%0b want 1000/0", fta.req.adr, fta.req.we); end
      tick();
      n_checks++; if (fta.req.cyc !== 1'b0) begin n_fail++; $display("FAIL read_req_single: got %0b want 0", fta.req.cyc); end
      tick();
      tick();
      fta.resp.ack = 1'b1;
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'hA5A5_A5A5_A5A5_A5A5;
      #1;
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL read_ack_early: got %0b want 0", ack_o); end
      tick();
      fta.resp = '0;
      n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL read_ack: got %0b want 1", ack_o); end
      n_checks++; if (err_o !== OKAY) begin n_fail++; $display("FAIL read_err: got %0d want %0d", err_o, OKAY); end
      n_checks++; if (dat_o !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_fail++; $display("FAIL read_dat: got %h want a5a5a5a5a5a5a5a5", dat_o); end
      tick();
      n_checks++; if (ack_o !== 1'b1) begin n_fail++; $display("FAIL read_ack_hold: got %0b want 1", ack_o); end
      end_cycle();
      n_checks++; if (ack_o !== 1'b0 || dat_o !== '0) begin n_fail++; $display("FAIL read_release: got ack %0b dat %h want 0/0", ack_o, dat_o); end
   endtask

   task automatic test_stall_posted();
      fta.resp.stall = 1'b1;
      start_req(1'b1, 32'h2000, 64'h1122_3344_5566_7788);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (fta.req.cyc !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got %0b want 0", i, fta.req.cyc); end
         if (i < 4) tick();
      end
      fta.resp.stall = 1'b0;
      #1;
      n_checks++; if (fta.req.cyc !== 1'b1 || fta.req.we !== 1'b1) begin n_fail++; $display("FAIL stall_issue: got cyc %0b we %0b want 1/1", fta.req.cyc, fta.req.we); end
      n_checks++; if (fta.req.cmd !== CMD_STORE) begin n_fail++; $display("FAIL stall_cmd: got %0d want %0d", fta.req.cmd, CMD_STORE); end
      n_checks++; if (fta.req.tid !== 8'd2) begin n_fail++; $display("FAIL stall_tid: got %0d want 2", fta.req.tid); end
      n_checks++; if (fta.req.data1 !== 64'h1122_3344_5566_7788 || fta.req.sel !== 8'hFF) begin n_fail++; $display("FAIL stall_data: got %h/%h want 1122334455667788/ff", fta.req.data1, fta.req.sel); end
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL stall_ack_early: got %0b want 0", ack_o); end
      tick();
      n_checks++; if (ack_o !== 1'b1 || err_o !== OKAY) begin n_fail++; $display("FAIL posted_ack: got %0b/%0d want 1/%0d", ack_o, err_o, OKAY); end
      n_checks++; if (fta.req.cyc !== 1'b0) begin n_fail++; $display("FAIL posted_req_drop: got %0b want 0", fta.req.cyc); end
      end_cycle();
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL posted_release: got %0b want 0", ack_o); end
   endtask

   task automatic test_retry();
      int n;
      start_req(1'b0, 32'h3000, '0);
      n_checks++; if (fta.req.cyc !== 1'b1 || fta.req.tid !== exp_tid) begin n_fail++; $display("FAIL retry_first: got %0b/%0d want 1/%0d", fta.req.cyc, fta.req.tid, exp_tid); end
      for (int r = 0; r < 2; r++) begin
         tick();
         fta.resp.rty = 1'b1;
         fta.resp.tid = exp_tid;
         tick();
         fta.resp = '0;
         wait_req(20, n);
         n_checks++; if (n !== BACKOFF) begin n_fail++; $display("FAIL retry_gap[%0d]: got %0d want %0d", r, n, BACKOFF); end
         n_checks++; if (fta.req.tid !== exp_tid) begin n_fail++; $display("FAIL retry_tid[%0d]: got %0d want %0d", r, fta.req.tid, exp_tid); end
      end
      tick();
      fta.resp.ack = 1'b1;
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'h0F0F_0F0F_1234_5678;
      tick();
      fta.resp = '0;
      n_checks++; if (ack_o !== 1'b1 || err_o !== OKAY) begin n_fail++; $display("FAIL retry_done: got %0b/%0d want 1/%0d", ack_o, err_o, OKAY); end
      n_checks++; if (dat_o !== 64'h0F0F_0F0F_1234_5678) begin n_fail++; $display("FAIL retry_dat: got %h want 0f0f0f0f12345678", dat_o); end
      end_cycle();
   endtask

   task automatic test_retry_exhaust();
      int pulses = 0;
      int n = 0;
      start_req(1'b0, 32'h4000, '0);
      fta.resp.rty = 1'b1;
      fta.resp.tid = exp_tid;
      while (ack_o !== 1'b1 && n < 300) begin
         if (fta.req.cyc === 1'b1) pulses++;
         tick();
         n++;
      end
      n_checks++; if (pulses !== RETRY_MAX + 1) begin n_fail++; $display("FAIL exhaust_pulses: got %0d want %0d", pulses, RETRY_MAX + 1); end
      n_checks++; if (ack_o !== 1'b1 || err_o !== ERR) begin n_fail++; $display("FAIL exhaust_err: got %0b/%0d want 1/%0d", ack_o, err_o, ERR); end
      n_checks++; if (dat_o !== '0) begin n_fail++; $display("FAIL exhaust_dat: got %h want 0", dat_o); end
      fta.resp = '0;
      end_cycle();
   endtask

   task automatic test_timeout();
      int n = 0;
      start_req(1'b0, 32'h5000, '0);
      tick();
      while (ack_o !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_checks++; if (n !== TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT); end
      n_checks++; if (err_o !== ERR) begin n_fail++; $display("FAIL timeout_err: got %0d want %0d", err_o, ERR); end
      end_cycle();
   endtask

   task automatic test_stale_tid();
      logic [7:0] old_tid;
      old_tid = exp_tid;
      start_req(1'b0, 32'h6000, '0);
      n_checks++; if (fta.req.tid !== old_tid + 8'd1) begin n_fail++; $display("FAIL stale_new_tid: got %0d want %0d", fta.req.tid, old_tid + 8'd1); end
      tick();
      fta.resp.ack = 1'b1;
      fta.resp.tid = old_tid;
      fta.resp.dat = 64'hDEAD_DEAD_DEAD_DEAD;
      repeat (3) tick();
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL stale_ignored: got %0b want 0", ack_o); end
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'h600D_600D_600D_600D;
      tick();
      fta.resp = '0;
      n_checks++; if (ack_o !== 1'b1 || dat_o !== 64'h600D_600D_600D_600D) begin n_fail++; $display("FAIL stale_match: got %0b/%h want 1/600d600d600d600d", ack_o, dat_o); end
      end_cycle();
   endtask

   task automatic test_precedence();
      start_req(1'b0, 32'h7000, '0);
      tick();
      fta.resp.ack = 1'b1;
      fta.resp.err = 1'b1;
      fta.resp.rty = 1'b1;
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'h0000_0000_CAFE_F00D;
      tick();
      fta.resp = '0;
      n_checks++; if (ack_o !== 1'b1 || err_o !== OKAY || dat_o !== 64'h0000_0000_CAFE_F00D) begin n_fail++; $display("FAIL prec_ack: got %0b/%0d/%h want 1/%0d/cafef00d", ack_o, err_o, dat_o, OKAY); end
      end_cycle();
      start_req(1'b0, 32'h7100, '0);
      tick();
      fta.resp.err = 1'b1;
      fta.resp.rty = 1'b1;
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'h1111_1111_1111_1111;
      tick();
      fta.resp = '0;
      n_checks++; if (ack_o !== 1'b1 || err_o !== ERR || dat_o !== '0) begin n_fail++; $display("FAIL prec_err: got %0b/%0d/%h want 1/%0d/0", ack_o, err_o, dat_o, ERR); end
      end_cycle();
   endtask

   task automatic test_reset_mid();
      start_req(1'b0, 32'h8000, '0);
      tick();
      #2 rst_i = 1'b0;
      exp_tid = 8'd0;
      #1;
      n_checks++; if (ack_o !== 1'b0 || err_o !== OKAY || dat_o !== '0 || fta.req !== '0) begin n_fail++; $display("FAIL rstwait_outputs: got %0b/%0d/%h/%h want 0", ack_o, err_o, dat_o, fta.req); end
      idle_bus();
      tick();
      #2 rst_i = 1'b1;
      tick();
      start_req(1'b0, 32'h8100, '0);
      n_checks++; if (fta.req.cyc !== 1'b1 || fta.req.tid !== 8'd1) begin n_fail++; $display("FAIL rstwait_next_tid: got %0b/%0d want 1/1", fta.req.cyc, fta.req.tid); end
      #2 rst_i = 1'b0;
      exp_tid = 8'd0;
      #1;
      n_checks++; if (fta.req.cyc !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %0b want 0", fta.req.cyc); end
      idle_bus();
      tick();
      #2 rst_i = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      cyc_i = 1'b1;
      stb_i = 1'b1;
      cs_i  = 1'b0;
      repeat (3) tick();
      n_checks++; if (fta.req.cyc !== 1'b0 || ack_o !== 1'b0) begin n_fail++; $display("FAIL cs_low: got %0b/%0b want 0/0", fta.req.cyc, ack_o); end
      idle_bus();
      tick();
      start_req(1'b0, 32'h9000, '0);
      n_checks++; if (fta.req.tid !== 8'd1) begin n_fail++; $display("FAIL abort_tid: got %0d want 1", fta.req.tid); end
      tick();
      idle_bus();
      tick();
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_ack: got %0b want 0", ack_o); end
      fta.resp.ack = 1'b1;
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'hBAD0_BAD0_BAD0_BAD0;
      start_req(1'b0, 32'h9100, '0);
      tick();
      tick();
      n_checks++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL late_resp_ignored: got %0b want 0", ack_o); end
      fta.resp.tid = exp_tid;
      fta.resp.dat = 64'h0000_0000_0000_0042;
      tick();
      fta.resp = '0;
      n_checks++; if (ack_o !== 1'b1 || dat_o !== 64'h42) begin n_fail++; $display("FAIL abort_next: got %0b/%h want 1/42", ack_o, dat_o); end
      end_cycle();
   endtask

   initial begin
      test_reset();
      test_read();
      test_stall_posted();
      test_retry();
      test_retry_exhaust();
      test_timeout();
      test_stale_tid();
      test_precedence();
      test_reset_mid();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/wb_to_fta_bridge_v2.md
# wb_to_fta_bridge_v2

Parametrised Wishbone-slave to FTA-master bridge that converts one classic Wishbone cycle into one tagged FTA request. It re-issues retried requests after a programmable back-off. It enforces a response timeout and optionally posts writes. It sits between a Wishbone-mastering core or peripheral cluster and the FTA system bus.

## Interface
- WID, 256: data width in bits (multiple of 8); sel width WID/8.
- RETRY_MAX, 10: retries accepted before the cycle fails with ERR (1..63).
- BACKOFF, 4: idle cycles between a rty response and the re-issue (0..255).
- TIMEOUT, 1023: WAIT cycles without a matching ack/rty/err before ERR (1..65535).
- POSTED_WR, 0: 1 = a write is acked as soon as it is issued.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- cs_i  in  1  bridge select; qualifies cyc_i/stb_i.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- ack_o  out  1  cycle done; held until cyc_i falls.
- err_o  out  3  fta_bus_pkg::OKAY / fta_bus_pkg::ERR; valid while ack_o is high.
- we_i  in  1  write enable.
- sel_i  in  WID/8  byte selects.
- adr_i  in  32  byte address.
- dat_i  in  WID  write data.
- dat_o  out  WID  read data; zero when ack_o is low.
- fta_o  fta_bus_interface.master  request/response bundle (req.cyc/we/cmd/sel/adr/data1/tid; resp.ack/rty/err/stall/tid/dat).

## Operation
- State machine: IDLE, ISSUE, WAIT, BACKOFF, DONE.
- IDLE:
  - A request is cyc_i & stb_i & cs_i.
  - On a request: latch we/sel/adr/dat, increment the 8-bit tid counter (wraps 255->0), clear the retry and timeout counters, set err_o to OKAY, go to ISSUE.
  - cs_i low: no action, no ack.
- ISSUE:
  - resp.stall high: hold req.cyc low and stay in ISSUE.
  - Otherwise drive req for exactly one cycle:
    - cyc=1, we, cmd = CMD_STORE or CMD_LOAD, sel, adr, data1, tid.
    - Read, or write with POSTED_WR=0 -> WAIT.
    - Write with POSTED_WR=1 -> DONE with err_o = OKAY.
- req is all-zero in every cycle it is not driven.
- WAIT (only responses with resp.tid equal to the current tid are honoured; others are ignored):
  - ack -> latch resp.dat into dat_o, go to DONE, OKAY.
  - err -> DONE, ERR, dat_o = 0.
  - rty with retry count < RETRY_MAX -> increment the retry count, go to BACKOFF.
  - rty with retry count == RETRY_MAX -> DONE, ERR.
  - Timeout counter reaches TIMEOUT -> DONE, ERR.
  - Precedence when several fire in the same cycle: ack > err > rty > timeout.
- BACKOFF: count BACKOFF cycles, then go to ISSUE; the same tid is reused for the re-issue.
- DONE: ack_o=1. When cyc_i falls -> IDLE, with ack_o=0 and dat_o=0 on the next edge.
- cyc_i falls in ISSUE, WAIT or BACKOFF: abort to IDLE with no ack. A late response carries a stale tid and is ignored.
- Reset, asserted at any time including mid-transaction:
  - state IDLE.
  - ack_o=0, err_o=OKAY, dat_o=0.
  - req=0.
  - tid counter=0, retry and timeout counters=0.

## Timing
- Request seen in IDLE at edge N: req.cyc is high during cycle N+1 if stall is low.
- Matching ack sampled at edge M: ack_o and dat_o are valid from edge M+1.
- Posted write: ack_o is high in the cycle after req.cyc was driven.
- Retry path: rty at edge R gives the re-issue at edge R+1+BACKOFF.
- Timeout counter starts at 0 on WAIT entry, is reset on each WAIT entry, and counts every WAIT cycle.
- Only one transaction is outstanding; a new request is accepted only in IDLE.

## Test plan
- Read: cyc/stb/cs, adr=0x1000, slave acks with dat=0xA5.. after 3 cycles -> one req.cyc pulse with cmd=LOAD and tid=1; ack_o=1, err_o=OKAY, dat_o=0xA5..; ack_o drops one cycle after cyc_i falls.
- Stall: resp.stall held for 5 cycles on a write, POSTED_WR=1 -> req.cyc issued on the first non-stall cycle; ack_o one cycle later with no wait for a response.
- Retry: slave answers rty twice, then ack, BACKOFF=4 -> three req pulses with the same tid spaced 5 cycles after each rty; final ack_o with OKAY.
- Retry exhaustion: rty forever, RETRY_MAX=10 -> 11 req pulses, then ack_o with err_o=ERR.
- Timeout and stale tid: TIMEOUT=20 with no response -> ERR at cycle 20 of WAIT. Next transaction: a response with the old tid is ignored and only the matching tid completes.
- Reset mid-WAIT: assert rst_i low -> all outputs zero and the FSM in IDLE asynchronously; the next request issues with tid=1.
